input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner_pkg.sv | 12 +
 rtl/debouncer.sv | 54 +++++
 rtl/input_conditioner.sv | 106 ++++++++++
 tb/tb_input_conditioner.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared constants and step FSM encoding for the panel input conditioner.
package input_conditioner_pkg;

   localparam int DEBOUNCE_CYCLES_DEF = 50000;
   localparam int CNT_W_DEF           = 16;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESSED = 1'b1
   } step_state_e;

endpackage

// File: rtl/debouncer.sv
// One raw input bit: two-flop synchronizer followed by a counting debouncer.
module debouncer
   import input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_level,
   output logic o_next
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d  = i_raw;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign o_level = stable_q;
   // Lets the parent see a level change in the same cycle it is committed.
   assign o_next  = stable_d;

endmodule

// File: rtl/input_conditioner.sv
// Front-panel conditioner: per-bit debounce, step pulse FSM, breakpoint latch.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic        i_oszClk,
   input  logic        i_reset,
   input  logic        i_btnStep,
   input  logic        i_btnReset,
   input  logic        i_swInstrNCycle,
   input  logic        i_swStepNRun,
   input  logic        i_swEnableBreakpoint,
   input  logic [7:0]  i_switches,
   output logic        o_stepPulse,
   output logic        o_resetReq,
   output logic        o_swInstrNCycle,
   output logic        o_swStepNRun,
   output logic        o_swEnableBreakpoint,
   output logic [7:0]  o_switches,
   output logic [15:0] o_breakpointAddress,
   output logic        o_breakpointValid
);

   localparam int NBITS = 13;

   logic [NBITS-1:0] raw;
   logic [NBITS-1:0] lvl;
   logic [NBITS-1:0] nxt;
   logic             unused_nxt;

   assign raw = {i_btnStep, i_btnReset, i_swInstrNCycle,
                 i_swStepNRun, i_swEnableBreakpoint, i_switches};

   for (genvar g = 0; g < NBITS; g++) begin : g_db
      debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_db (
         .clk    (i_oszClk),
         .rst    (i_reset),
         .i_raw  (raw[g]),
         .o_level(lvl[g]),
         .o_next (nxt[g])
      );
   end

   assign unused_nxt = ^{nxt[12], nxt[10:0]};

   step_state_e state_q, state_d;
   logic        pulse_q, pulse_d;
   logic [15:0] bp_addr_q, bp_addr_d;
   logic        bp_valid_q, bp_valid_d;

   always_comb begin
      state_d = state_q;
      pulse_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (lvl[12]) begin
               state_d = PRESSED;
               pulse_d = ~lvl[11];
            end
         end
         PRESSED: begin
            if (!lvl[12]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture the switches as they stand before any same-cycle update.
   always_comb begin
      bp_addr_d  = bp_addr_q;
      bp_valid_d = bp_valid_q;
      if (lvl[11] && !nxt[11]) begin
         bp_addr_d  = {8'h00, lvl[7:0]};
         bp_valid_d = 1'b1;
      end
   end

   always_ff @(posedge i_oszClk) begin
      if (i_reset) begin
         state_q    <= IDLE;
         pulse_q    <= 1'b0;
         bp_addr_q  <= '0;
         bp_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pulse_q    <= pulse_d;
         bp_addr_q  <= bp_addr_d;
         bp_valid_q <= bp_valid_d;
      end
   end

   assign o_stepPulse          = pulse_q;
   assign o_resetReq           = lvl[11];
   assign o_swInstrNCycle      = lvl[10];
   assign o_swStepNRun         = lvl[9];
   assign o_swEnableBreakpoint = lvl[8];
   assign o_switches           = lvl[7:0];
   assign o_breakpointAddress  = bp_addr_q;
   assign o_breakpointValid    = bp_valid_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with a 4-cycle debounce window.
module tb_input_conditioner;

   logic        clk;
   logic        rst;
   logic        btn_step, btn_reset;
   logic        sw_instr, sw_step_run, sw_en_bp;
   logic [7:0]  sw;
   logic        step_pulse, reset_req;
   logic        o_instr, o_step_run, o_en_bp;
   logic [7:0]  o_sw;
   logic [15:0] bp_addr;
   logic        bp_valid;

   input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (3)
   ) dut (
      .i_oszClk            (clk),
      .i_reset             (rst),
      .i_btnStep           (btn_step),
      .i_btnReset          (btn_reset),
      .i_swInstrNCycle     (sw_instr),
      .i_swStepNRun        (sw_step_run),
      .i_swEnableBreakpoint(sw_en_bp),
      .i_switches          (sw),
      .o_stepPulse         (step_pulse),
      .o_resetReq          (reset_req),
      .o_swInstrNCycle     (o_instr),
      .o_swStepNRun        (o_step_run),
      .o_swEnableBreakpoint(o_en_bp),
      .o_switches          (o_sw),
      .o_breakpointAddress (bp_addr),
      .o_breakpointValid   (bp_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          c;
      int          s;
      logic [31:0] v;
      string       n;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   localparam int S_PULSE = 0, S_RREQ = 1, S_INSTR = 2, S_SRUN = 3;
   localparam int S_ENBP = 4, S_SW = 5, S_ADDR = 6, S_VALID = 7, S_ANY = 8;

   function automatic void exp_at(int c, int s, logic [31:0] v, string n);
      exp_t e;
      int   i;
      e = '{c: c, s: s, v: v, n: n};
      i = 0;
      while (i < q.size() && q[i].c <= c) i++;
      q.insert(i, e);
   endfunction

   function automatic logic [31:0] pick(int s);
      case (s)
         S_PULSE: return {31'd0, step_pulse};
         S_RREQ:  return {31'd0, reset_req};
         S_INSTR: return {31'd0, o_instr};
         S_SRUN:  return {31'd0, o_step_run};
         S_ENBP:  return {31'd0, o_en_bp};
         S_SW:    return {24'd0, o_sw};
         S_ADDR:  return {16'd0, bp_addr};
         S_VALID: return {31'd0, bp_valid};
         default: return {31'd0, |{step_pulse, reset_req, o_instr,
                             o_step_run, o_en_bp, o_sw, bp_addr, bp_valid}};
      endcase
   endfunction

   exp_t m;
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].c <= cyc) begin
         m = q.pop_front();
         n_cmp++;
         if (m.c != cyc || pick(m.s) !== m.v) begin
            n_err++;
            $display("FAIL %s @cyc %0d (due %0d): got %h want %h",
                     m.n, cyc, m.c, pick(m.s), m.v);
         end
      end
   end

   task automatic go_to(int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      btn_step = 1'b1;
      btn_reset = 1'b1;
      sw_instr = 1'b1;
      sw_step_run = 1'b1;
      sw_en_bp = 1'b1;
      sw = 8'hFF;

      // Reset with every raw input high.
      for (int c = 1; c <= 8; c++) exp_at(c, S_ANY, 0, "reset_quiet");
      exp_at(9, S_SW, 32'hFF, "sw_rise_after_reset");
      exp_at(9, S_RREQ, 1, "rreq_rise_after_reset");
      exp_at(9, S_INSTR, 1, "instr_rise");
      exp_at(9, S_SRUN, 1, "srun_rise");
      exp_at(9, S_ENBP, 1, "enbp_rise");
      exp_at(14, S_VALID, 0, "bp_valid_before_fall");
      exp_at(15, S_RREQ, 0, "rreq_fall");
      exp_at(15, S_SW, 0, "sw_fall");
      exp_at(15, S_ADDR, 32'h00FF, "bp_addr_old_switches");
      exp_at(15, S_VALID, 1, "bp_valid_set");
      exp_at(15, S_SRUN, 0, "srun_fall");
      for (int c = 4; c <= 20; c++) exp_at(c, S_PULSE, 0, "pulse_none_init");
      go_to(3);
      rst = 1'b0;
      go_to(9);
      btn_step = 1'b0;
      btn_reset = 1'b0;
      sw_instr = 1'b0;
      sw_step_run = 1'b0;
      sw_en_bp = 1'b0;
      sw = 8'h00;

      // Short step glitch, then a clean long press.
      for (int c = 21; c <= 60; c++)
         exp_at(c, S_PULSE, (c == 37), "step_pulse");
      go_to(20);
      btn_step = 1'b1;
      go_to(23);
      btn_step = 1'b0;
      go_to(30);
      btn_step = 1'b1;
      go_to(50);
      btn_step = 1'b0;

      // Bouncing data switches.
      for (int c = 61; c <= 85; c++) exp_at(c, S_SW, 0, "sw_bounce_hold");
      exp_at(86, S_SW, 32'hFF, "sw_settled");
      for (int j = 0; j < 10; j++) begin
         go_to(60 + 2 * j);
         sw = (j % 2 == 0) ? 8'hFF : 8'h00;
      end
      go_to(80);
      sw = 8'hFF;

      // Breakpoint capture on reset-button release.
      exp_at(105, S_RREQ, 1, "rreq_held");
      exp_at(105, S_ADDR, 32'h00FF, "bp_addr_before_release");
      exp_at(106, S_RREQ, 0, "rreq_release");
      exp_at(106, S_ADDR, 32'h00A5, "bp_addr_a5");
      exp_at(106, S_VALID, 1, "bp_valid_a5");
      exp_at(116, S_SW, 32'h3C, "sw_3c");
      for (int c = 116; c <= 120; c++)
         exp_at(c, S_ADDR, 32'h00A5, "bp_addr_hold");
      go_to(90);
      sw = 8'hA5;
      btn_reset = 1'b1;
      go_to(100);
      btn_reset = 1'b0;
      go_to(110);
      sw = 8'h3C;

      // Step pressed during reset request, held past release.
      for (int c = 126; c <= 190; c++)
         exp_at(c, S_PULSE, (c == 172), "step_under_reset");
      exp_at(148, S_ADDR, 32'h003C, "bp_addr_3c");
      go_to(125);
      btn_reset = 1'b1;
      go_to(133);
      btn_step = 1'b1;
      go_to(142);
      btn_reset = 1'b0;
      go_to(155);
      btn_step = 1'b0;
      go_to(165);
      btn_step = 1'b1;
      go_to(180);
      btn_step = 1'b0;

      // Reset in the middle of a debounce count.
      for (int c = 196; c <= 205; c++)
         exp_at(c, S_SRUN, 0, "srun_mid_reset_hold");
      exp_at(206, S_SRUN, 1, "srun_after_reset");
      exp_at(199, S_ANY, 0, "mid_reset_clear");
      exp_at(200, S_VALID, 0, "bp_valid_cleared");
      exp_at(201, S_SW, 0, "sw_cleared");
      exp_at(205, S_SW, 0, "sw_not_yet");
      exp_at(206, S_SW, 32'h3C, "sw_recovered");
      go_to(195);
      sw_step_run = 1'b1;
      go_to(198);
      rst = 1'b1;
      go_to(200);
      rst = 1'b0;

      go_to(215);
      if (q.size() != 0) begin
         n_err += q.size();
         $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
